cs_sliding_detector: RTL and testbench

//  Parametrised carrier-sense detector for the RX0 DSP chain. Computes the
//  I/Q magnitude, keeps a power-of-two sliding-window average, and compares
//  it against hysteresis thresholds with a programmable hold-off. Sits after
//  the DDC strobe and drives carrier_present to the TX gating/MAC logic.

---
 rtl/cs_sliding_detector.sv | 170 +++++++++++++++++
 tb/tb_cs_sliding_detector.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/cs_sliding_detector.sv
// Carrier-sense detector: I/Q magnitude estimate, sliding-window average and a
// hysteresis/hold-off FSM that drives carrier_present.
module cs_sliding_detector #(
  parameter int WIDTH    = 16,
  parameter int LOG2_WIN = 4,
  parameter int SR_BASE  = 66,
  parameter int HOLD_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_stb,
  input  logic [7:0]       set_addr,
  input  logic [31:0]      set_data,
  input  logic [WIDTH-1:0] i_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic             strobe,
  input  logic             run,
  output logic [WIDTH:0]   avg_out,
  output logic             avg_valid,
  output logic             carrier_present
);

  localparam int DEPTH = 1 << LOG2_WIN;
  localparam int MW    = WIDTH + 1;
  localparam int SW    = WIDTH + 1 + LOG2_WIN;
  localparam logic [LOG2_WIN:0] FULL = (LOG2_WIN+1)'(DEPTH);

  typedef enum logic [2:0] {OFF, FILL, CLEAR, BUSY, HOLD} state_t;

  logic              enable;
  logic [MW-1:0]     thr_hi, thr_lo, thr_lo_eff;
  logic [HOLD_W-1:0] holdoff, hold_cnt;
  logic              clr;
  logic [2:0]        vld_pipe;
  logic [MW-1:0]     a, b, mx, mn, mag, old;
  logic [SW-1:0]     sum;
  logic [LOG2_WIN-1:0] wr_ptr;
  logic [LOG2_WIN:0] fill_cnt;
  logic [MW-1:0]     ram [DEPTH];
  logic              hi, lo;
  state_t            state;
  logic              unused;

  assign unused = ^set_data[31:MW];

  function automatic logic [MW-1:0] mag_abs(input logic [WIDTH-1:0] x);
    logic [MW-1:0] ext;
    ext = {x[WIDTH-1], x};
    return x[WIDTH-1] ? -ext : ext;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable  <= 1'b1;
      thr_hi  <= MW'(100);
      thr_lo  <= MW'(80);
      holdoff <= '0;
    end else if (set_stb) begin
      if (set_addr == 8'(SR_BASE))     enable  <= set_data[0];
      if (set_addr == 8'(SR_BASE + 1)) thr_hi  <= set_data[MW-1:0];
      if (set_addr == 8'(SR_BASE + 2)) thr_lo  <= set_data[MW-1:0];
      if (set_addr == 8'(SR_BASE + 3)) holdoff <= set_data[HOLD_W-1:0];
    end
  end

  assign thr_lo_eff = (thr_lo < thr_hi) ? thr_lo : thr_hi;
  assign clr        = !(run && enable);

  assign mx  = (a > b) ? a : b;
  assign mn  = (a > b) ? b : a;
  // Until the window has filled once, the RAM holds stale data: treat it as zero.
  assign old = (fill_cnt == FULL) ? ram[wr_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      a         <= '0;
      b         <= '0;
      mag       <= '0;
      sum       <= '0;
      wr_ptr    <= '0;
      fill_cnt  <= '0;
      avg_out   <= '0;
      avg_valid <= 1'b0;
    end else begin
      avg_out <= sum[SW-1:LOG2_WIN];
      if (clr) begin
        vld_pipe  <= '0;
        sum       <= '0;
        wr_ptr    <= '0;
        fill_cnt  <= '0;
        avg_valid <= 1'b0;
      end else begin
        vld_pipe[0] <= strobe;
        vld_pipe[1] <= vld_pipe[0];
        vld_pipe[2] <= vld_pipe[1] && (fill_cnt >= FULL - 1'b1);
        avg_valid   <= vld_pipe[2];
        if (strobe) begin
          a <= mag_abs(i_in);
          b <= mag_abs(q_in);
        end
        if (vld_pipe[0]) mag <= mx + (mn >> 2) + (mn >> 3);
        if (vld_pipe[1]) begin
          sum    <= sum + SW'(mag) - SW'(old);
          wr_ptr <= wr_ptr + 1'b1;
          if (fill_cnt != FULL) fill_cnt <= fill_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) ram[k] <= '0;
    end else if (!clr && vld_pipe[1]) begin
      ram[wr_ptr] <= mag;
    end
  end

  assign hi = avg_valid && (avg_out >= thr_hi);
  assign lo = avg_valid && (avg_out < thr_lo_eff);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= OFF;
      hold_cnt        <= '0;
      carrier_present <= 1'b0;
    end else if (clr) begin
      state           <= OFF;
      hold_cnt        <= '0;
      carrier_present <= 1'b0;
    end else begin
      case (state)
        OFF: state <= FILL;
        FILL: if (avg_valid) begin
          if (hi) begin
            state           <= BUSY;
            carrier_present <= 1'b1;
          end else begin
            state <= CLEAR;
          end
        end
        CLEAR: if (hi) begin
          state           <= BUSY;
          carrier_present <= 1'b1;
        end
        BUSY: if (lo) begin
          state    <= HOLD;
          hold_cnt <= holdoff;
        end
        HOLD: begin
          // A fresh high average beats an expiring hold-off.
          if (hi) begin
            state <= BUSY;
          end else if (hold_cnt == '0) begin
            state           <= CLEAR;
            carrier_present <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        default: begin
          state           <= OFF;
          carrier_present <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cs_sliding_detector.sv
// Directed bench for cs_sliding_detector: table of steady-state windows plus
// hand sequences for fill, hysteresis, hold-off, abort and reset.
module tb_cs_sliding_detector;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        set_stb = 1'b0;
  logic [7:0]  set_addr = '0;
  logic [31:0] set_data = '0;
  logic [15:0] i_in = '0, q_in = '0;
  logic        strobe = 1'b0;
  logic        run = 1'b0;
  logic [16:0] avg_out;
  logic        avg_valid;
  logic        carrier_present;

  int n_cmp = 0;
  int n_bad = 0;

  cs_sliding_detector dut (
    .clk(clk), .rst_n(rst_n), .set_stb(set_stb), .set_addr(set_addr),
    .set_data(set_data), .i_in(i_in), .q_in(q_in), .strobe(strobe), .run(run),
    .avg_out(avg_out), .avg_valid(avg_valid), .carrier_present(carrier_present)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] i;
    logic [15:0] q;
    logic [16:0] avg;
    logic        pres;
  } vec_t;

  vec_t tbl [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [15:0] i, input logic [15:0] q);
    i_in = i;
    q_in = q;
    strobe = 1'b1;
    tick(1);
    strobe = 1'b0;
  endtask

  task automatic send_n(input int n, input logic [15:0] i, input logic [15:0] q);
    repeat (n) send(i, q);
  endtask

  task automatic set_reg(input int off, input logic [31:0] d);
    set_addr = 8'(66 + off);
    set_data = d;
    set_stb = 1'b1;
    tick(1);
    set_stb = 1'b0;
  endtask

  initial begin
    logic seen;

    tbl[0]  = '{16'd1000,  16'd0,     17'd1000,  1'b1};
    tbl[1]  = '{16'd300,   16'd0,     17'd300,   1'b1};
    tbl[2]  = '{16'd100,   16'd0,     17'd100,   1'b0};
    tbl[3]  = '{16'h8000,  16'h8000,  17'd45056, 1'b1};
    tbl[4]  = '{16'd300,   16'd400,   17'd512,   1'b1};
    tbl[5]  = '{-16'sd300, -16'sd400, 17'd512,   1'b1};
    tbl[6]  = '{16'd0,     16'd0,     17'd0,     1'b0};
    tbl[7]  = '{16'd500,   16'd0,     17'd500,   1'b1};
    tbl[8]  = '{16'd200,   16'd0,     17'd200,   1'b1};
    tbl[9]  = '{16'd7,     16'd3,     17'd7,     1'b0};
    tbl[10] = '{16'sd32767, 16'h8000, 17'd45054, 1'b1};

    // reset state
    tick(3);
    check("rst_avg", avg_out, 0);
    check("rst_valid", avg_valid, 0);
    check("rst_present", carrier_present, 0);
    rst_n = 1'b1;
    tick(1);
    set_reg(1, 500);
    set_reg(2, 200);

    // fill: nothing before the 16th sample has been through the pipe
    run = 1'b1;
    tick(1);
    seen = 1'b0;
    for (int k = 0; k < 16; k++) begin
      send(16'd1000, 16'd0);
      if (avg_valid || carrier_present) seen = 1'b1;
    end
    tick(2);
    if (avg_valid || carrier_present) seen = 1'b1;
    check("t1_no_early", seen, 0);
    tick(1);
    check("t1_valid", avg_valid, 1);
    check("t1_avg", avg_out, 1000);
    check("t1_present_late", carrier_present, 0);
    tick(1);
    check("t1_present", carrier_present, 1);
    check("t1_valid_pulse", avg_valid, 0);

    // steady-state windows
    for (int v = 0; v < 11; v++) begin
      send_n(16, tbl[v].i, tbl[v].q);
      tick(3);
      check($sformatf("vec%0d_avg", v), avg_out, tbl[v].avg);
      check($sformatf("vec%0d_valid", v), avg_valid, 1);
      tick(1);
      check($sformatf("vec%0d_present", v), carrier_present, tbl[v].pres);
      tick(2);
    end

    // hysteresis with holdoff=0: 15th sample of 100 drops avg to 156
    send_n(16, 16'd1000, 16'd0);
    tick(4);
    check("t3_busy", carrier_present, 1);
    send_n(15, 16'd100, 16'd0);
    tick(3);
    check("t3_avg", avg_out, 156);
    tick(1);
    check("t3_hold_cycle", carrier_present, 1);
    tick(1);
    check("t3_drop", carrier_present, 0);

    // hold-off 20: a quick return keeps carrier up
    set_reg(3, 20);
    send_n(16, 16'd1000, 16'd0);
    tick(4);
    check("t4_busy", carrier_present, 1);
    send_n(15, 16'd100, 16'd0);
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      if (!carrier_present) seen = 1'b1;
    end
    send(16'h8000, 16'h8000);
    for (int k = 0; k < 30; k++) begin
      if (!carrier_present) seen = 1'b1;
      tick(1);
    end
    check("t4_no_drop", seen, 0);
    // without the return it drops 21 cycles after entering hold
    send_n(16, 16'd1000, 16'd0);
    tick(4);
    send_n(15, 16'd100, 16'd0);
    tick(24);
    check("t4_still_hold", carrier_present, 1);
    tick(1);
    check("t4_drop", carrier_present, 0);

    // abort mid-fill and in busy
    run = 1'b1;
    send_n(8, 16'd1000, 16'd0);
    run = 1'b0;
    tick(1);
    check("t5_fill_abort", carrier_present, 0);
    run = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      send(16'd1000, 16'd0);
      if (avg_valid) seen = 1'b1;
    end
    for (int k = 0; k < 3; k++) begin
      tick(1);
      if (avg_valid) seen = 1'b1;
    end
    check("t5_refill_no_valid", seen, 0);
    send(16'd1000, 16'd0);
    tick(3);
    check("t5_valid", avg_valid, 1);
    check("t5_avg", avg_out, 1000);
    tick(1);
    check("t5_busy", carrier_present, 1);
    run = 1'b0;
    tick(1);
    check("t5_busy_abort", carrier_present, 0);
    tick(1);
    check("t5_avg_cleared", avg_out, 0);

    // async reset between edges while busy
    run = 1'b1;
    tick(1);
    send_n(16, 16'd1000, 16'd0);
    tick(4);
    check("t6_busy", carrier_present, 1);
    #3 rst_n = 1'b0;
    #1;
    check("t6_rst_avg", avg_out, 0);
    check("t6_rst_present", carrier_present, 0);
    check("t6_rst_valid", avg_valid, 0);
    tick(2);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      send(16'd1000, 16'd0);
      if (avg_valid || carrier_present) seen = 1'b1;
    end
    for (int k = 0; k < 3; k++) begin
      tick(1);
      if (avg_valid) seen = 1'b1;
    end
    check("t6_refill_no_valid", seen, 0);
    send(16'd1000, 16'd0);
    tick(3);
    check("t6_valid", avg_valid, 1);
    tick(1);
    check("t6_busy_again", carrier_present, 1);
    set_reg(0, 0);
    tick(1);
    check("t6_disable", carrier_present, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
